// File: rtl/mux16_pkg.sv
// Shared widths, state encoding and limits for the mux_16x1 serial sequencer.
package mux16_pkg;
  localparam int DATA_W     = 16;
  localparam int SEL_W      = 4;
  localparam int CNT_W      = 4;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/mux16_serial_ctrl_if.sv
// Word-in / bit-out handshake bundle of the mux_16x1 sequencer.
interface mux16_serial_ctrl_if;
  import mux16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_bit;
  logic              ser_last;

  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_bit, ser_last
  );

  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_bit, ser_last
  );
endinterface

// File: rtl/mux16_sel_encode.sv
// Bit index to mux_16x1 select lines; the odd ordering follows the mux tree wiring.
module mux16_sel_encode
  import mux16_pkg::*;
(
  input  logic [SEL_W-1:0] idx,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             s3
);
  assign s2 = idx[3];
  assign s3 = idx[2];
  assign s0 = idx[1];
  assign s1 = idx[0];
endmodule

// File: rtl/mux16_serial_ctrl.sv
// Holds a word on the mux inputs, walks the selects, samples y after a settle
// time and streams one bit per position, flagging any bit that disagrees.
module mux16_serial_ctrl
  import mux16_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mux16_serial_ctrl_if.slave  bus,
  output logic [DATA_W-1:0]   di,
  output logic                s0,
  output logic                s1,
  output logic                s2,
  output logic                s3,
  input  logic                y,
  output logic                done,
  output logic                err
);
  localparam logic [SEL_W-1:0] IDX_FIRST  = MSB_FIRST ? SEL_W'(15) : SEL_W'(0);
  localparam logic [SEL_W-1:0] IDX_LAST   = MSB_FIRST ? SEL_W'(0)  : SEL_W'(15);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] di_nxt;
  logic [SEL_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sv_q, sv_nxt;
  logic              sb_q, sb_nxt;
  logic              sl_q, sl_nxt;
  logic              done_nxt, err_nxt;

  assign bus.in_ready  = (state == IDLE);
  assign bus.ser_valid = sv_q;
  assign bus.ser_bit   = sb_q;
  assign bus.ser_last  = sl_q;

  // idx is a register, so the selects are glitch-free despite the encoder.
  mux16_sel_encode u_sel (
    .idx (idx),
    .s0  (s0),
    .s1  (s1),
    .s2  (s2),
    .s3  (s3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      di    <= '0;
      idx   <= '0;
      cnt   <= '0;
      sv_q  <= 1'b0;
      sb_q  <= 1'b0;
      sl_q  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      di    <= di_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      sv_q  <= sv_nxt;
      sb_q  <= sb_nxt;
      sl_q  <= sl_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    di_nxt    = di;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    sv_nxt    = sv_q;
    sb_nxt    = sb_q;
    sl_nxt    = sl_q;
    done_nxt  = 1'b0;
    err_nxt   = err;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          di_nxt    = bus.in_data;
          idx_nxt   = IDX_FIRST;
          cnt_nxt   = SETTLE_CNT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        // Sample on the last settle cycle so WAIT spans exactly SETTLE clocks.
        if (cnt == CNT_W'(1)) begin
          sb_nxt    = y;
          err_nxt   = err | (y != di[idx]);
          sl_nxt    = (idx == IDX_LAST);
          sv_nxt    = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (sv_q && bus.ser_ready) begin
          sv_nxt = 1'b0;
          if (sl_q) begin
            sl_nxt    = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = MSB_FIRST ? idx - 1'b1 : idx + 1'b1;
            cnt_nxt   = SETTLE_CNT;
            state_nxt = WAIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mux16_serial_ctrl.sv
// Two sequencer instances (ascending/SETTLE=2, descending/SETTLE=3), each
// driving a behavioural mux_16x1 with an optional stuck position.
module tb_mux16_serial_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        in_valid [2];
  logic [15:0] in_data  [2];
  logic        ser_ready[2];
  logic        in_ready_w [2];
  logic        ser_valid_w[2];
  logic        ser_bit_w  [2];
  logic        ser_last_w [2];
  logic        done_w     [2];
  logic        err_w      [2];
  logic        y_w        [2];
  logic [15:0] di_w       [2];
  logic [3:0]  sel_w      [2];
  logic        fault_en   [2];
  logic [3:0]  fault_idx  [2];
  logic        fault_val  [2];
  logic        exp_err    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mux16_serial_ctrl_if bus ();
    logic s0, s1, s2, s3;
    assign bus.in_valid  = in_valid[g];
    assign bus.in_data   = in_data[g];
    assign bus.ser_ready = ser_ready[g];
    assign in_ready_w[g]  = bus.in_ready;
    assign ser_valid_w[g] = bus.ser_valid;
    assign ser_bit_w[g]   = bus.ser_bit;
    assign ser_last_w[g]  = bus.ser_last;
    // i = 8*s2 + 4*s3 + 2*s0 + s1
    assign sel_w[g] = {s2, s3, s0, s1};
    assign y_w[g] = (fault_en[g] && sel_w[g] == fault_idx[g]) ? fault_val[g] : di_w[g][sel_w[g]];

    mux16_serial_ctrl #(.SETTLE(g == 0 ? 2 : 3), .MSB_FIRST(g == 1)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .di   (di_w[g]),
      .s0   (s0),
      .s1   (s1),
      .s2   (s2),
      .s3   (s3),
      .y    (y_w[g]),
      .done (done_w[g]),
      .err  (err_w[g])
    );
  end

  typedef struct {
    int          d;
    logic [15:0] data;
    logic [15:0] seq;     // expected bits in emission order
    bit          f;
    int          fi;
    bit          fv;
    int          stall_k;
    int          stall_len;
    bit          rnd;
    bit          offer;
    int          abort_k;
    bit          exp_err;
  } vec_t;

  function automatic int st(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic [15:0] ref_seq(input logic [15:0] data, input bit msb,
                                          input bit f, input int fi, input bit fv);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) begin
      int i;
      i = msb ? 15 - k : k;
      r[k] = (f && i == fi) ? fv : data[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic idle_checks(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_in_ready"}, d, in_ready_w[d], 1);
      chk({tag, "_ser_valid"}, d, ser_valid_w[d], 0);
      chk({tag, "_di"}, d, di_w[d], 0);
      chk({tag, "_sel"}, d, sel_w[d], 0);
      chk({tag, "_err"}, d, err_w[d], 0);
      chk({tag, "_done"}, d, done_w[d], 0);
    end
  endtask

  task automatic run_word(input vec_t v);
    int n, i, t0, d, hits;
    bit stable, e;
    logic b0;
    logic [3:0] s_hold;
    d = v.d;
    fault_en[d] = v.f; fault_idx[d] = 4'(v.fi); fault_val[d] = v.fv;
    ser_ready[d] = 1'b1;
    n = 0;
    while (!in_ready_w[d] && n < 50) begin tick(); n++; end
    chk("accept_ready", d, in_ready_w[d], 1);
    in_valid[d] = 1'b1; in_data[d] = v.data;
    tick();
    t0 = cyc;
    if (v.offer) in_data[d] = ~v.data;
    else in_valid[d] = 1'b0;
    chk("busy_not_ready", d, in_ready_w[d], 0);
    e = exp_err[d];
    for (int k = 0; k < 16; k++) begin
      n = 0;
      while (!ser_valid_w[d] && n < 40) begin tick(); n++; end
      chk("bit_latency", d, n, st(d));
      if (n >= 40) begin in_valid[d] = 1'b0; return; end
      i = (d == 1) ? 15 - k : k;
      e = e | (v.seq[k] != v.data[i]);
      chk("ser_bit", d, ser_bit_w[d], v.seq[k]);
      chk("ser_last", d, ser_last_w[d], k == 15);
      chk("sel", d, sel_w[d], i);
      chk("di_held", d, di_w[d], v.data);
      chk("err_run", d, err_w[d], e);
      chk("no_early_done", d, done_w[d], 0);
      if (k == v.abort_k) begin
        rst = 1'b1; in_valid[d] = 1'b1; in_data[d] = 16'hBEEF;
        tick();
        rst = 1'b0; in_valid[d] = 1'b0;
        fault_en[0] = 1'b0; fault_en[1] = 1'b0;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        idle_checks("abort");
        hits = 0;
        for (int c = 0; c < 20; c++) begin
          tick();
          if (done_w[d] || ser_valid_w[d]) hits++;
        end
        chk("abort_quiet", d, hits, 0);
        return;
      end
      if (v.offer && k == 15) in_valid[d] = 1'b0;
      if (k == v.stall_k) begin
        ser_ready[d] = 1'b0;
        b0 = ser_bit_w[d]; s_hold = sel_w[d]; stable = 1'b1;
        repeat (v.stall_len) begin
          tick();
          if (!ser_valid_w[d] || ser_bit_w[d] !== b0 || sel_w[d] !== s_hold) stable = 1'b0;
        end
        chk("stall_hold", d, stable, 1);
        ser_ready[d] = 1'b1;
      end else if (v.rnd) begin
        n = $urandom_range(0, 2);
        if (n > 0) begin
          ser_ready[d] = 1'b0;
          repeat (n) tick();
          ser_ready[d] = 1'b1;
        end
      end
      tick();
    end
    chk("done_pulse", d, done_w[d], 1);
    chk("last_cleared", d, ser_last_w[d], 0);
    chk("valid_cleared", d, ser_valid_w[d], 0);
    chk("back_idle", d, in_ready_w[d], 1);
    chk("err_word", d, err_w[d], v.exp_err);
    if (!v.rnd && v.stall_k < 0) chk("word_cycles", d, cyc - t0, 16 * (st(d) + 1));
    tick();
    chk("done_one_cycle", d, done_w[d], 0);
    exp_err[d] = e;
    fault_en[d] = 1'b0;
  endtask

  vec_t tv[7];

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; ser_ready[d] = 1'b0;
      fault_en[d] = 1'b0; fault_idx[d] = '0; fault_val[d] = 1'b0; exp_err[d] = 1'b0;
    end

    tv[0] = '{d:0, data:16'hA5C3, seq:16'hA5C3, f:0, fi:0, fv:0, stall_k:-1, stall_len:0, rnd:0, offer:0, abort_k:-1, exp_err:0};
    tv[1] = '{d:1, data:16'h8001, seq:16'h8001, f:0, fi:0, fv:0, stall_k:-1, stall_len:0, rnd:0, offer:0, abort_k:-1, exp_err:0};
    tv[2] = '{d:0, data:16'h0F0F, seq:16'h0F0F, f:0, fi:0, fv:0, stall_k:5, stall_len:10, rnd:0, offer:1, abort_k:-1, exp_err:0};
    tv[3] = '{d:0, data:16'hFFFF, seq:16'hFF7F, f:1, fi:7, fv:0, stall_k:-1, stall_len:0, rnd:0, offer:0, abort_k:-1, exp_err:1};
    tv[4] = '{d:0, data:16'h0000, seq:16'h0000, f:0, fi:0, fv:0, stall_k:-1, stall_len:0, rnd:0, offer:0, abort_k:-1, exp_err:1};
    tv[5] = '{d:0, data:16'h3C3C, seq:16'h3C3C, f:0, fi:0, fv:0, stall_k:-1, stall_len:0, rnd:0, offer:1, abort_k:9, exp_err:0};
    tv[6] = '{d:0, data:16'h0001, seq:16'h0001, f:0, fi:0, fv:0, stall_k:-1, stall_len:0, rnd:0, offer:0, abort_k:-1, exp_err:0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    idle_checks("reset");

    foreach (tv[t]) run_word(tv[t]);

    for (int r = 0; r < 24; r++) begin
      vec_t v;
      v.d = $urandom_range(0, 1);
      v.data = 16'($urandom);
      v.f = ($urandom_range(0, 3) == 0);
      v.fi = $urandom_range(0, 15);
      v.fv = 1'($urandom_range(0, 1));
      v.seq = ref_seq(v.data, v.d == 1, v.f, v.fi, v.fv);
      v.stall_k = $urandom_range(0, 31);
      v.stall_len = $urandom_range(1, 6);
      v.rnd = 1'b1;
      v.offer = 1'($urandom_range(0, 1));
      v.abort_k = -1;
      v.exp_err = exp_err[v.d] | (v.f && v.fv != v.data[v.fi]);
      run_word(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux16_serial_ctrl.md
Name: mux16_serial_ctrl

Overview:
- Upstream sequencer for the gate-level mux_16x1.
- Accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the four select lines through all 16 positions, waits a programmable settle time at each, samples the mux output, and emits one serial bit per position over a valid/ready stream.
- Checks every sampled bit against the stored word and flags any mismatch, giving a built-in self-check of the mux.

Parameters:
- SETTLE, 2, cycles between a select change and the sampling of y; legal range 1..15.
- MSB_FIRST, 0, 0 = emit index 0 first (ascending); 1 = emit index 15 first (descending).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  word offered
- in_ready  output  1  block can accept a word; high only in IDLE
- in_data  input  16  word to serialize
- di  output  16  to mux_16x1 di; registered copy of the accepted word
- s0, s1, s2, s3  output  1 each  to mux_16x1 select inputs
- y  input  1  from mux_16x1 output
- ser_valid  output  1  serial bit available
- ser_ready  input  1  consumer accepts bit
- ser_bit  output  1  sampled mux output
- ser_last  output  1  qualifies the final bit of the word
- done  output  1  one-cycle pulse after the last bit handshake
- err  output  1  sticky: some sampled bit differed from the stored word

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, di=0, s0..s3=0, idx=0, cnt=0, ser_valid=0, ser_bit=0, ser_last=0, done=0, err=0. in_ready is 1 in the first cycle after rst deasserts.
- Select mapping (fixed by the mux structure): for bit index i, s2=i[3], s3=i[2], s0=i[1], s1=i[0]. So i = 8*s2 + 4*s3 + 2*s0 + s1.
- All outputs are registered except in_ready, which is (state==IDLE).
- IDLE:
  - in_ready=1.
  - On in_valid: di<=in_data; idx<=0, or 15 if MSB_FIRST; cnt<=SETTLE; go to WAIT.
- WAIT:
  - Selects driven from idx; cnt decrements each cycle.
  - In the cycle with cnt==1: ser_bit<=y; err<=err | (y != di[idx]); ser_last<=(idx is the final index); ser_valid<=1; go to EMIT.
  - WAIT therefore lasts exactly SETTLE cycles.
- EMIT:
  - ser_valid, ser_bit and ser_last are held stable until ser_ready.
  - Selects stay unchanged while the bit is held.
  - On ser_valid && ser_ready with ser_last=0: ser_valid<=0; idx steps by +1 (or −1 if MSB_FIRST); cnt<=SETTLE; go to WAIT.
  - On ser_valid && ser_ready with ser_last=1: ser_valid<=0; ser_last<=0; done<=1 for one cycle; go to IDLE.
- Latency:
  - First ser_valid rises SETTLE cycles after the accept edge.
  - With ser_ready tied high, each bit costs SETTLE+1 cycles.
  - A word costs 16*(SETTLE+1) cycles plus at least 1 IDLE cycle before the next accept.
- Boundary conditions:
  - in_valid outside IDLE is ignored (in_ready=0); in_data is not sampled.
  - idx never wraps within a word. The last index is 15 (ascending) or 0 (descending).
  - ser_ready held low: the block stalls indefinitely in EMIT; no bit is lost or resampled.
  - ser_ready high outside EMIT has no effect.
  - err is sticky across words and clears only on rst.
  - rst mid-word: abandon the word at the next edge, return all registers to reset values, no done pulse.
  - rst has priority over every handshake in the same cycle.

Decomposition:
- Package mux16_pkg:
  - DATA_W=16, SEL_W=4.
  - State encoding: IDLE, WAIT, EMIT.
  - Constant for the maximum SETTLE value.
- One combinational sub-module, mux16_sel_encode:
  - Input: 4-bit index.
  - Outputs: s0..s3, using the mapping above.
  - Shared with any future mux_16x1 driver.
- Counter, FSM and checker stay in the top module.

Test Plan:
- Reset then idle: rst high 3 cycles, then low → in_ready=1, ser_valid=0, di=0, s0..s3=0, err=0.
- Ascending word, SETTLE=2, ser_ready=1, real mux_16x1 connected, in_data=16'hA5C3:
  - ser_bit sequence (i=0..15) is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - ser_last only on the 16th bit; done pulses once 48 cycles after accept; err=0.
- MSB_FIRST=1, in_data=16'h8001 → first bit 1 (i=15), bits 2..15 are 0, last bit 1 (i=0); selects at first bit are s2=1, s3=1, s0=1, s1=1.
- Backpressure: ser_ready low 10 cycles on bit 5 → ser_valid, ser_bit and selects held constant; bit 6 appears only after ser_ready rises; total bit count stays 16.
- Fault injection: bench forces y=0 while idx=7, in_data=16'hFFFF → err rises with bit 7 and stays 1 through the next word; a later rst clears it.
- Mid-word reset plus ignored offer: in_valid held high with new data during EMIT → no second accept. rst asserted at bit 9 → no done pulse; next word 16'h0001 serializes cleanly from index 0.
